// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low matrix keypad scanner with frame-level debounce.
// Emits one key_flag pulse per accepted press; rearms after release.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] value,
    output logic       key_flag,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [7:0] DEB = 8'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {F_EMPTY, F_SINGLE, F_MULTI} frame_e;
    typedef enum logic [1:0] {S_IDLE, S_PRESS_CHK, S_HELD, S_REL_CHK} state_e;

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    frame_e        frm_q, frm_d;
    logic [3:0]    fcode_q, fcode_d;
    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    value_q, value_d;
    logic          flag_q, flag_d;
    logic          held_q, held_d;

    logic       tick, resolve;
    logic [3:0] lows;
    logic [1:0] lrow;
    frame_e     base_frm, nxt_frm;
    logic [3:0] nxt_code;
    logic [7:0] cnt_inc;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        unique case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    assign col      = ~(4'b0001 << idx_q);
    assign value    = value_q;
    assign key_flag = flag_q;
    assign key_held = held_q;

    assign lows    = ~row;
    assign tick    = (div_q == DIV_LAST);
    assign resolve = tick && (idx_q == 2'd3);
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_comb begin
        lrow = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (lows[i]) lrow = 2'(i);
        end
    end

    // Merge this column's sample into the frame accumulated so far.
    always_comb begin
        base_frm = (idx_q == 2'd0) ? F_EMPTY : frm_q;
        nxt_frm  = base_frm;
        nxt_code = fcode_q;
        if (lows != 4'd0) begin
            if ((lows & (lows - 4'd1)) != 4'd0 || base_frm != F_EMPTY) begin
                nxt_frm = F_MULTI;
            end else begin
                nxt_frm  = F_SINGLE;
                nxt_code = key_code(lrow, idx_q);
            end
        end
    end

    always_comb begin
        div_d   = tick ? '0 : div_q + 1'b1;
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
        frm_d   = tick ? nxt_frm : frm_q;
        fcode_d = tick ? nxt_code : fcode_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        value_d = value_q;
        flag_d  = 1'b0;
        held_d  = held_q;
        if (resolve) begin
            unique case (state_q)
                S_IDLE: begin
                    if (nxt_frm == F_SINGLE) begin
                        cand_d  = nxt_code;
                        cnt_d   = 8'd1;
                        state_d = S_PRESS_CHK;
                    end
                end
                S_PRESS_CHK: begin
                    if (nxt_frm == F_SINGLE && nxt_code == cand_q) begin
                        cnt_d = cnt_inc;
                    end else if (nxt_frm == F_SINGLE) begin
                        cand_d = nxt_code;
                        cnt_d  = 8'd1;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (nxt_frm == F_EMPTY) begin
                        cnt_d   = 8'd1;
                        state_d = S_REL_CHK;
                    end
                end
                default: begin
                    if (nxt_frm == F_EMPTY) cnt_d = cnt_inc;
                    else state_d = S_HELD;
                end
            endcase
            // Acceptance is checked on the post-update count so that a
            // single-frame debounce accepts straight out of IDLE/HELD.
            if (state_d == S_PRESS_CHK && cnt_d >= DEB) begin
                value_d = cand_d;
                flag_d  = 1'b1;
                held_d  = 1'b1;
                cnt_d   = 8'd0;
                state_d = S_HELD;
            end else if (state_d == S_REL_CHK && cnt_d >= DEB) begin
                held_d  = 1'b0;
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            idx_q   <= 2'd0;
            frm_q   <= F_EMPTY;
            fcode_q <= 4'd0;
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            cand_q  <= 4'd0;
            value_q <= 4'd0;
            flag_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            fcode_q <= fcode_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            value_q <= value_d;
            flag_q  <= flag_d;
            held_q  <= held_d;
        end
    end

endmodule
